// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// Divide support in the users of this package is enabled with MULDIV_DIV_EN.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = $clog2(STEPS);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply, or restoring divide
// when MULDIV_DIV_EN is defined. {hi,lo} is the product, or remainder/quotient.
module muldiv_step
    import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic            is_div,
`endif
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
`endif

    // NOTE: every output gets a value before any conditional override, so no latch is inferred.
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        hi_nxt = sum[XLEN:1];
        lo_nxt = {sum[0], lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
        if (is_div) begin
            // A borrow out of the top bit means the trial subtraction is undone.
            hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
        end
`endif
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage, stalling the pipeline while busy.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 complete at once with 0.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1Data_ex,
    input  logic [XLEN-1:0] rs2Data_ex,
    input  logic [4:0]      rdAddr_ex,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdAddr_md
);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  count;
    op_e               op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q, hi_q, lo_q, hi_step, lo_step;

    op_e               op_in;
    logic              launch;
    logic              signed_a, signed_b, neg_a, neg_b, neg_res;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              fast;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_res;

    assign op_in  = op_e'(op);
    assign launch = (state == IDLE) && start && !flush;

    // Iterations run on magnitudes; the result sign is remembered for FIX.
    always_comb begin
        signed_a = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        signed_b = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        neg_a    = signed_a && rs1Data_ex[XLEN-1];
        neg_b    = signed_b && rs2Data_ex[XLEN-1];
        mag_a    = neg_a ? -rs1Data_ex : rs1Data_ex;
        mag_b    = neg_b ? -rs2Data_ex : rs2Data_ex;
        neg_res  = (op_in inside {OP_REM, OP_REMU}) ? neg_a : (neg_a ^ neg_b);
    end

`ifdef MULDIV_DIV_EN
    logic div_zero, div_ovf;

    always_comb begin
        div_zero = op[2] && (rs2Data_ex == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                   (rs1Data_ex == {1'b1, {(XLEN-1){1'b0}}}) && (rs2Data_ex == '1);
        fast     = div_zero || div_ovf;
        fast_res = '0;
        if (div_zero)
            fast_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1Data_ex;
        else if (div_ovf)
            fast_res = (op_in == OP_DIV) ? rs1Data_ex : '0;
    end
`else
    always_comb begin
        fast     = op[2];
        fast_res = '0;
    end
`endif

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .is_div (op_q[2]),
`endif
        .hi     (hi_q),
        .lo     (lo_q),
        .b      (b_q),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    always_comb begin
        fix_res = '0;
        prod    = {hi_q, lo_q};
        if (neg_q)
            prod = -prod;
        case (op_q)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              fix_res = neg_q ? -lo_q : lo_q;
            default:                      fix_res = neg_q ? -hi_q : hi_q;
`else
            default:                      fix_res = '0;
`endif
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = fast ? DONE : RUN;
            RUN:     if (count == CNT_W'(STEPS - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_comb begin
        stall = ((state == IDLE) && start) || (state == RUN) || (state == FIX);
        done  = (state == DONE) && !flush;
    end

    // NOTE: operand and accumulator registers are reset too, so a reset leaves no stale operands visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result    <= '0;
            rdAddr_md <= '0;
        end else begin
            case (state)
                IDLE: if (launch) begin
                    op_q  <= op_in;
                    rd_q  <= rdAddr_ex;
                    neg_q <= neg_res;
                    b_q   <= mag_b;
                    hi_q  <= '0;
                    lo_q  <= mag_a;
                    count <= '0;
                    if (fast) begin
                        result    <= fast_res;
                        rdAddr_md <= rdAddr_ex;
                    end
                end
                RUN: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    count <= count + CNT_W'(1);
                end
                FIX: if (!flush) begin
                    result    <= fix_res;
                    rdAddr_md <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule
